// File: rtl/rs232_pkg.sv
// Shared constants and helpers for the rs232_tx arbiter: frame timing and FSM encodings.
package rs232_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StGrant  = 2'd1;
  localparam logic [1:0] StLaunch = 2'd2;
  localparam logic [1:0] StFrame  = 2'd3;

  function automatic int unsigned bit_cycles(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned frame_cycles(input int unsigned frame_bits,
                                               input int unsigned clk_hz,
                                               input int unsigned baud);
    return frame_bits * bit_cycles(clk_hz, baud);
  endfunction

  // Index width, kept at least one bit so a single-requester build still has a grant_id port.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs232_rr_pick.sv
// Combinational round-robin find-first: lowest set bit searching upward from ptr+1, wrapping.
module rs232_rr_pick
  import rs232_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IdW = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdW-1:0]  ptr,
  output logic            valid,
  output logic [IdW-1:0]  idx
);

  always_comb begin
    int unsigned j;
    logic [IdW-1:0] jj;
    valid = 1'b0;
    idx   = '0;
    // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
    for (int unsigned k = NREQ; k >= 1; k--) begin
      j  = (32'(ptr) + k) % NREQ;
      jj = IdW'(j);
      if (req[jj]) begin
        valid = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/rs232_tx_arb.sv
// Round-robin arbiter/sequencer sharing one rs232_tx among NREQ byte requesters.
// Define RS232_ARB_LOCK_EN to keep a requester granted until it sends a byte with req_last set.
module rs232_tx_arb
  import rs232_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FRAME_BITS = 12,
  localparam int unsigned IdW = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        tx_data,
  output logic              tx_ctrl,
  output logic              busy,
  output logic [IdW-1:0]    grant_id
);

  localparam int unsigned FrameCycles = frame_cycles(FRAME_BITS, CLK_HZ, BAUD);
  localparam int unsigned TimerW      = $clog2(FrameCycles + 1);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(FrameCycles - 1);

  logic [1:0]        state_q, state_d;
  logic [IdW-1:0]    grant_q, grant_d;
  logic [IdW-1:0]    rr_q, rr_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              busy_q, busy_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic [NREQ-1:0]   eligible;
  logic              pick_valid;
  logic [IdW-1:0]    pick_idx;
  logic [7:0]        req_byte [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign req_byte[g] = req_data[8*g +: 8];
  end

`ifdef RS232_ARB_LOCK_EN
  logic              locked_q, locked_d;
  logic [IdW-1:0]    lock_id_q, lock_id_d;
  logic [NREQ-1:0]   lock_mask;

  always_comb begin
    lock_mask = '0;
    lock_mask[lock_id_q] = 1'b1;
  end

  assign eligible = locked_q ? (req & lock_mask) : req;
`else
  logic unused_req_last;
  assign unused_req_last = ^req_last;
  assign eligible = req;
`endif

  rs232_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (eligible),
    .ptr   (rr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    timer_d   = timer_q;
    busy_d    = busy_q;
    tx_data_d = tx_data_q;
`ifdef RS232_ARB_LOCK_EN
    locked_d  = locked_q;
    lock_id_d = lock_id_q;
`endif
    unique case (state_q)
      StIdle: begin
        // busy rises with the grant so it is already high in the ack cycle.
        if (pick_valid) begin
          grant_d = pick_idx;
          busy_d  = 1'b1;
          state_d = StGrant;
        end
      end
      StGrant: begin
        tx_data_d = req_byte[grant_q];
        timer_d   = TimerLoad;
        state_d   = StLaunch;
`ifdef RS232_ARB_LOCK_EN
        if (!locked_q) rr_d = grant_q;
        locked_d  = !req_last[grant_q];
        lock_id_d = grant_q;
`else
        rr_d = grant_q;
`endif
      end
      StLaunch: begin
        timer_d = timer_q - TimerW'(1);
        state_d = StFrame;
      end
      StFrame: begin
        if (timer_q == '0) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      rr_q      <= IdW'(NREQ - 1);
      timer_q   <= '0;
      busy_q    <= 1'b0;
      tx_data_q <= 8'hFF;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      tx_data_q <= tx_data_d;
    end
  end

`ifdef RS232_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked_q  <= 1'b0;
      lock_id_q <= '0;
    end else begin
      locked_q  <= locked_d;
      lock_id_q <= lock_id_d;
    end
  end
`endif

  always_comb begin
    ack = '0;
    if (state_q == StGrant) ack[grant_q] = 1'b1;
  end

  assign tx_ctrl  = (state_q == StLaunch);
  assign busy     = busy_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;

endmodule

// File: doc/rs232_tx_arb.md
Name: rs232_tx_arb

Overview:
Round-robin arbiter and sequencer that shares one rs232_tx transmitter among NREQ byte requesters.
- Accepts one byte at a time through a per-requester req/ack handshake.
- Holds the byte stable on the transmitter data input for the whole frame.
- Issues a single-cycle launch pulse to the transmitter.
- Times the frame internally, because rs232_tx exposes no busy/done signal.

Parameters:
NREQ, 4, number of requesters (2..8)
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, serial bit rate; must match the transmitter's divider
FRAME_BITS, 12, bit periods reserved per frame (1 launch-alignment + start + 8 data + stop + 1 margin)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
req  in  NREQ  per-requester byte request; held high until matching ack
req_data  in  8*NREQ  byte of requester i at [8*i+7:8*i]; stable while req[i]=1
req_last  in  NREQ  byte is last of a message (used only with lock feature)
ack  out  NREQ  one-cycle pulse: byte of requester i accepted
tx_data  out  8  byte to rs232_tx data input
tx_ctrl  out  1  one-cycle launch pulse to rs232_tx ctrl
busy  out  1  high from grant until frame timer expires
grant_id  out  $clog2(NREQ)  index of current or most recent grantee

Behaviour:
- Reset values: ack=0, tx_data=8'hFF, tx_ctrl=0, busy=0, grant_id=0, rr pointer=NREQ-1, frame timer=0, state=IDLE.
- Derived constants:
  - BIT_CYCLES = CLK_HZ/BAUD (integer division).
  - FRAME_CYCLES = FRAME_BITS*BIT_CYCLES.
  - Timer width = $clog2(FRAME_CYCLES+1).
- FSM states: IDLE, GRANT, LAUNCH, FRAME.
- IDLE:
  - If any eligible req bit is set, pick the first set index searching upward from rr pointer+1 with modulo-NREQ wrap.
  - Register the winner in grant_id; go to GRANT.
- GRANT (1 cycle):
  - tx_data <= winner's byte.
  - ack[winner]=1 for exactly this cycle.
  - rr pointer <= winner.
  - busy <= 1.
  - Go to LAUNCH.
- LAUNCH (1 cycle):
  - tx_ctrl=1; load timer with FRAME_CYCLES-1.
  - Go to FRAME.
- FRAME:
  - Timer decrements each cycle; tx_data is held constant.
  - At timer==0: busy <= 0, go to IDLE.
- IDLE to GRANT has latency 1 cycle from req assertion. Back-to-back minimum spacing between tx_ctrl pulses is FRAME_CYCLES+2 cycles.
- ack never asserts for two requesters in the same cycle. ack never asserts while busy was already 1 before GRANT.
- A requester that deasserts req before ack is dropped without side effects. Requesters must not change req_data while req is high.
- req changes during GRANT, LAUNCH or FRAME are ignored until the return to IDLE.
- Reset mid-frame:
  - All outputs return to reset values immediately.
  - tx_data=8'hFF; the transmitter is reset from the same rst, so no partial frame continues.
- NREQ=1 degenerates to a pass-through sequencer; the rr search always picks index 0.

Optional Feature:
RS232_ARB_LOCK_EN
- Defined:
  - Granting a byte with req_last[i]=0 locks arbitration to i.
  - In IDLE only req[i] is eligible; other requests wait.
  - The lock clears when a byte with req_last[i]=1 is acked, or on reset.
  - While locked the rr pointer is not updated, so the post-message rotation continues from i+1.
  - Requesters must finish a message with req_last=1.
- Undefined: req_last is ignored and arbitration rotates after every byte.

Decomposition:
- Package rs232_pkg holds BIT_CYCLES/FRAME_CYCLES computation functions and the FSM state enum (IDLE, GRANT, LAUNCH, FRAME).
- One sub-module, rs232_rr_pick: combinational round-robin find-first from pointer+1 over NREQ bits, outputs a valid flag and an index. Used by IDLE.
- rs232_tx is instantiated by the parent, not inside this block.

Test Plan:
- Only req[2]=1 with data 8'hA5 → ack[2] one cycle later, tx_data=8'hA5, tx_ctrl pulse next cycle, busy high for FRAME_CYCLES+1 cycles; serial line decodes 0xA5 at 115200.
- req=4'b1111 held, data 8'h10..8'h13 → grant order 0,1,2,3,0, ack pulses spaced FRAME_CYCLES+2 cycles apart.
- req[1]=1 asserted mid-frame of requester 0 → no ack until busy falls; ack[1] 1 cycle after IDLE.
- rst low during FRAME → tx_data=8'hFF, busy=0, tx_ctrl=0 immediately; after release, pending req[3] is granted first (pointer=NREQ-1 wraps to 0..3 search, 3 is the only one set).
- LOCK_EN: req[0] sends 3 bytes with last=0,0,1 while req[1] is held → bytes 0,0,0 then 1; without the macro, order is 0,1,0,1.
- req[2] pulsed for 1 cycle before IDLE check → no ack, no tx_ctrl, busy stays 0.
